// File: rtl/piano_voice_sched.sv
// piano_voice_sched
// -----------------
// Shares one external 8-bit waveform ROM among up to 8 key voices. Every
// sample_tick starts a frame: the pressed-key chord is latched, voices 0..7
// are walked in order and each active voice issues one ROM read addressed by
// the top 8 bits of its phase accumulator. The returned samples are summed,
// scaled down by a power of two chosen from the active-voice count, and the
// result is registered on wave.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   t[7:0]       raw key inputs, bit k = key k pressed
//   inc          packed phase increments, voice k = inc[k*PHASE_W +: PHASE_W]
//   sample_tick  one-cycle request for a new output sample
//   rom_en       ROM read strobe
//   rom_addr     ROM address
//   rom_data     ROM read data, valid the cycle after rom_en
//   wave         normalized unsigned output sample
//   sample_valid one-cycle pulse when wave updates
//   busy         high while a frame is in progress
//   overrun      sticky: a sample_tick arrived while a frame was in progress
//
// Optional feature (macro PIANO_DEBOUNCE_EN): per-key debounce; a key's
// chord bit only changes after the raw input disagreed with it on DEB_TICKS
// consecutive sample_ticks. Without the macro t is latched directly.

module piano_voice_sched #(
    parameter int PHASE_W   = 16,
    parameter int DEB_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           t,
    input  logic [8*PHASE_W-1:0] inc,
    input  logic                 sample_tick,
    output logic                 rom_en,
    output logic [7:0]           rom_addr,
    input  logic [7:0]           rom_data,
    output logic [7:0]           wave,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, NORM} state_t;

    state_t               state;
    logic [7:0]           chord;
    logic [3:0]           cnt;
    logic [3:0]           idx;
    logic [10:0]          acc;
    logic [PHASE_W-1:0]   phase [8];
    logic [7:0]           key_vec;
    logic [PHASE_W-1:0]   inc_sel;
    logic                 issue;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Power-of-two normalization: shift grows with the voice count so that
    // the sum of up to 2^sh full-scale samples still fits 8 bits.
    function automatic logic [7:0] norm_wave(input logic [10:0] a, input logic [3:0] n);
        logic [7:0] w;
        case (n)
            4'd0:       w = 8'h80;
            4'd1:       w = a[7:0];
            4'd2:       w = a[8:1];
            4'd3, 4'd4: w = a[9:2];
            default:    w = a[10:3];
        endcase
        return w;
    endfunction

`ifdef PIANO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [7:0]    deb;
    logic [CW-1:0] deb_cnt [8];
    logic [7:0]    deb_next;

    // Debounced value including this tick's update, so the chord latched on
    // the deciding tick already sees the new key state.
    always_comb begin
        deb_next = deb;
        for (int k = 0; k < 8; k++) begin
            if (t[k] != deb[k] && deb_cnt[k] == CW'(DEB_TICKS - 1)) begin
                deb_next[k] = t[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                deb_cnt[k] <= '0;
            end
        end else if (sample_tick) begin
            deb <= deb_next;
            for (int k = 0; k < 8; k++) begin
                if (t[k] != deb[k] && deb_cnt[k] != CW'(DEB_TICKS - 1)) begin
                    deb_cnt[k] <= deb_cnt[k] + CW'(1);
                end else begin
                    deb_cnt[k] <= '0;
                end
            end
        end
    end

    assign key_vec = deb_next;
`else
    assign key_vec = t;
`endif

    // Read strobe is decoded from registered state so rom_data lines up with
    // the FETCH cycle that follows an issuing SCAN cycle.
    assign issue    = (state == SCAN) && !idx[3] && chord[idx[2:0]];
    assign rom_en   = issue;
    assign rom_addr = issue ? phase[idx[2:0]][PHASE_W-1 -: 8] : 8'h00;
    assign inc_sel  = inc[idx[2:0]*PHASE_W +: PHASE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            chord        <= 8'h00;
            cnt          <= 4'd0;
            idx          <= 4'd0;
            acc          <= 11'd0;
            wave         <= 8'h80;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                phase[k] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        chord <= key_vec;
                        cnt   <= popcount8(key_vec);
                        acc   <= 11'd0;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                        state <= SCAN;
                        // Released keys restart at phase 0 when pressed again.
                        for (int k = 0; k < 8; k++) begin
                            if (!key_vec[k]) begin
                                phase[k] <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (idx[3]) begin
                        state <= NORM;
                    end else if (chord[idx[2:0]]) begin
                        state <= FETCH;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                FETCH: begin
                    acc             <= acc + {3'b000, rom_data};
                    phase[idx[2:0]] <= phase[idx[2:0]] + inc_sel;
                    idx             <= idx + 4'd1;
                    state           <= SCAN;
                end
                NORM: begin
                    wave         <= norm_wave(acc, cnt);
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
